// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: definitions shared by the instruction fetch port.
//   fetch_state_e   - fetch FSM states (IDLE, REQ, WAIT, OUT)
//   RESET_PC        - boot address; inst_addr resets to it
//   NOP_INST        - instruction placed in the output register for an address error
//   addr_misaligned - true when a fetch address is not word aligned
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;
  localparam logic [31:0] NOP_INST = 32'h00000000;

  function automatic logic addr_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_port_if.sv
// inst_fetch_port_if: SRAM-like instruction memory bus.
//   inst_req     - request, held until inst_addr_ok
//   inst_addr    - fetch address, stable while inst_req is high
//   inst_addr_ok - slave accepted the address
//   inst_data_ok - read data valid (earliest one cycle after inst_addr_ok)
//   inst_rdata   - read data
// Modports: master (fetch port side), slave (memory side).
interface inst_fetch_port_if #(
  parameter int WIDTH = 32
);
  logic             inst_req;
  logic [WIDTH-1:0] inst_addr;
  logic             inst_addr_ok;
  logic             inst_data_ok;
  logic [WIDTH-1:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/inst_fetch_port.sv
// inst_fetch_port: instruction-side fetch port. Turns the PC register value
// into a single outstanding memory read, presents the result to decode in a
// valid/stall output register and pulses pc_en when decode consumes it.
// Redirect flushes discard any in-flight response so no wrong-path
// instruction reaches decode.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   bus (master)    - instruction memory bus (inst_req/inst_addr/...)
//   pc_addr, pc_en  - current PC in; one-cycle advance pulse out
//   flush           - redirect, same cycle the PC register loads its target
//   pipe_stall      - decode cannot accept this cycle
//   if_valid, if_inst, if_pc - output register to decode
//   if_adel         - fetch address error
// Build option: define IFETCH_ADEL_EN to turn misaligned PCs into an
// address-error "instruction" without touching the bus; otherwise if_adel
// is constant 0 and every address is issued as-is.
module inst_fetch_port
  import cpu_fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  inst_fetch_port_if.master bus,
  input  logic [WIDTH-1:0] pc_addr,
  output logic             pc_en,
  input  logic             flush,
  input  logic             pipe_stall,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_inst,
  output logic [WIDTH-1:0] if_pc,
  output logic             if_adel
);

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic             drop;      // in-flight response belongs to a flushed path
  logic [WIDTH-1:0] pend_pc;   // PC of the outstanding fetch
  logic             req_c;
  logic             pc_en_c;
  logic             consume;
  logic             misaligned;

  assign misaligned = addr_misaligned(pc_addr[1:0]);
  assign consume    = (state == OUT) && !flush && !pipe_stall;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and bus/PC control outputs
  always_comb begin
    state_next = state;
    req_c      = 1'b0;
    pc_en_c    = 1'b0;
    case (state)
      IDLE: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
`ifdef IFETCH_ADEL_EN
          if (misaligned) begin
            state_next = OUT;
          end else begin
            state_next = REQ;
          end
`else
          state_next = REQ;
`endif
        end
      end
      REQ: begin
        // request stays up through a flush; the response is dropped instead
        req_c = 1'b1;
        if (bus.inst_addr_ok) begin
          state_next = WAIT;
        end else begin
          state_next = REQ;
        end
      end
      WAIT: begin
        if (bus.inst_data_ok) begin
          if (drop || flush) begin
            state_next = IDLE;
          end else begin
            state_next = OUT;
          end
        end else begin
          state_next = WAIT;
        end
      end
      OUT: begin
        pc_en_c = consume;
        if (flush || !pipe_stall) begin
          state_next = IDLE;
        end else begin
          state_next = OUT;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.inst_req = req_c;
  assign pc_en        = pc_en_c;

`ifdef IFETCH_ADEL_EN
  logic adel;
  assign if_adel = adel;
`else
  assign if_adel = 1'b0;
`endif

  // Address, drop flag and decode output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.inst_addr <= WIDTH'(RESET_PC);
      pend_pc       <= WIDTH'(RESET_PC);
      drop          <= 1'b0;
      if_valid      <= 1'b0;
      if_inst       <= {WIDTH{1'b0}};
      if_pc         <= {WIDTH{1'b0}};
`ifdef IFETCH_ADEL_EN
      adel          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!flush) begin
`ifdef IFETCH_ADEL_EN
            if (misaligned) begin
              if_valid <= 1'b1;
              if_inst  <= WIDTH'(NOP_INST);
              if_pc    <= pc_addr;
              adel     <= 1'b1;
            end else begin
              bus.inst_addr <= pc_addr;
              pend_pc       <= pc_addr;
            end
`else
            bus.inst_addr <= pc_addr;
            pend_pc       <= pc_addr;
`endif
          end
        end
        REQ: begin
          if (flush) begin
            drop <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.inst_data_ok) begin
            drop <= 1'b0;
            if (!drop && !flush) begin
              if_valid <= 1'b1;
              if_inst  <= bus.inst_rdata;
              if_pc    <= pend_pc;
            end
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        OUT: begin
          if (flush || !pipe_stall) begin
            if_valid <= 1'b0;
`ifdef IFETCH_ADEL_EN
            adel     <= 1'b0;
`endif
          end
        end
        default: begin
          drop <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_port.sv
// Self-checking bench for inst_fetch_port: a PC register model, a
// configurable-latency memory slave and a scoreboard of expected
// (pc, instruction) pairs compared whenever decode consumes an instruction.
module tb_inst_fetch_port;
  import cpu_fetch_pkg::*;

  localparam int WIDTH = 32;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_en;
  logic        flush;
  logic        pipe_stall;
  logic [31:0] target;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_adel;

  inst_fetch_port_if #(.WIDTH(WIDTH)) bus ();

  inst_fetch_port #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .pc_addr   (pc),
    .pc_en     (pc_en),
    .flush     (flush),
    .pipe_stall(pipe_stall),
    .if_valid  (if_valid),
    .if_inst   (if_inst),
    .if_pc     (if_pc),
    .if_adel   (if_adel)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  exp_t popped;
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;
  int   n_consume = 0;
  int   n_pcen = 0;
  int   consume_cyc[$];

  // slave configuration and state
  int          addr_dly = 0;
  int          data_dly = 0;
  int          req_cnt = 0;
  int          wait_cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h24080001 + (a - RESET_PC);
  endfunction

  task automatic push_exp(input logic [31:0] a);
    sb.push_back('{pc: a, inst: mem_word(a)});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_consumes(input int n, input string tag);
    for (int i = 0; i < 200 && n_consume < n; i++) step();
    check_val(tag, 32'(n_consume), 32'(n));
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 60 && !if_valid; i++) step();
    check_val(tag, 32'(if_valid), 32'd1);
  endtask

  // PC register: loads the redirect target on flush, advances on pc_en
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else if (flush) pc <= target;
    else if (pc_en) pc <= pc + 32'd4;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // memory slave: addr_ok after addr_dly waiting cycles, data_ok data_dly cycles after that
  always @(posedge clk) begin
    #1;
    if (rst) begin
      bus.inst_addr_ok = 1'b0;
      bus.inst_data_ok = 1'b0;
      bus.inst_rdata   = 32'h0;
      pend = 1'b0;
      req_cnt = 0;
      wait_cnt = 0;
    end else begin
      bus.inst_addr_ok = 1'b0;
      bus.inst_data_ok = 1'b0;
      if (pend) begin
        if (wait_cnt == data_dly) begin
          bus.inst_data_ok = 1'b1;
          bus.inst_rdata   = mem_word(paddr);
          pend = 1'b0;
        end else begin
          wait_cnt++;
        end
      end else if (bus.inst_req) begin
        if (req_cnt == addr_dly) begin
          bus.inst_addr_ok = 1'b1;
          paddr = bus.inst_addr;
          pend = 1'b1;
          wait_cnt = 0;
          req_cnt = 0;
        end else begin
          req_cnt++;
        end
      end
    end
  end

  // consume monitor: every instruction taken by decode is checked against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (pc_en) begin
        n_pcen++;
        check_val("pc_en_needs_valid", 32'(if_valid), 32'd1);
      end
      if (if_valid && pc_en) begin
        n_consume++;
        consume_cyc.push_back(cycle);
        if (sb.size() == 0) begin
          check_val("unexpected_consume_pc", if_pc, 32'hffffffff);
        end else begin
          popped = sb.pop_front();
          check_val("sb_pc", if_pc, popped.pc);
          check_val("sb_inst", if_inst, popped.inst);
        end
      end
    end
  end

  initial begin
    int base;
    int viol;
    logic found;
    logic req_seen;

    rst = 1'b1;
    flush = 1'b0;
    pipe_stall = 1'b0;
    target = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    check_val("rst_inst_req", 32'(bus.inst_req), 32'd0);
    check_val("rst_inst_addr", bus.inst_addr, 32'hbfc00000);
    check_val("rst_if_valid", 32'(if_valid), 32'd0);
    check_val("rst_if_inst", if_inst, 32'd0);
    check_val("rst_if_pc", if_pc, 32'd0);
    check_val("rst_if_adel", 32'(if_adel), 32'd0);
    check_val("rst_pc_en", 32'(pc_en), 32'd0);
    rst = 1'b0;

    // zero-wait streaming: 4 cycles per instruction
    push_exp(32'hbfc00000);
    push_exp(32'hbfc00004);
    push_exp(32'hbfc00008);
    push_exp(32'hbfc0000c);
    wait_consumes(3, "zero_wait_three");
    pipe_stall = 1'b1;
    if (consume_cyc.size() >= 3) begin
      check_val("throughput_1", 32'(consume_cyc[1] - consume_cyc[0]), 32'd4);
      check_val("throughput_2", 32'(consume_cyc[2] - consume_cyc[1]), 32'd4);
    end else begin
      check_val("throughput_count", 32'(consume_cyc.size()), 32'd3);
    end

    // stall in OUT for 5 cycles: outputs hold, no pc_en
    wait_valid("stall_reach_out");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("stall_valid", 32'(if_valid), 32'd1);
      check_val("stall_pc", if_pc, 32'hbfc0000c);
      check_val("stall_inst", if_inst, mem_word(32'hbfc0000c));
      check_val("stall_pc_en", 32'(pc_en), 32'd0);
    end
    addr_dly = 3;
    data_dly = 2;
    push_exp(32'hbfc00010);
    base = n_pcen;
    step();
    pipe_stall = 1'b0;
    wait_consumes(4, "stall_release");
    check_val("stall_single_pc_en", 32'(n_pcen - base), 32'd1);

    // addr_ok delayed 3 cycles: request and address stable for 4 cycles
    for (int i = 0; i < 20 && !bus.inst_req; i++) step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("dly_req", 32'(bus.inst_req), 32'd1);
      check_val("dly_addr", bus.inst_addr, 32'hbfc00010);
    end
    addr_dly = 0;
    wait_consumes(5, "dly_delivered");

    // flush in WAIT, data arrives 2 cycles later and must be dropped
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = pend && !bus.inst_addr_ok && !bus.inst_data_ok && (paddr == 32'hbfc00014);
    end
    check_val("flush_wait_found", 32'(found), 32'd1);
    flush = 1'b1;
    target = 32'hbfc00380;
    pipe_stall = 1'b1;
    step();
    flush = 1'b0;
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (if_valid) viol++;
      if (bus.inst_req && bus.inst_addr == 32'hbfc00380) break;
    end
    check_val("flush_wait_no_valid", 32'(viol), 32'd0);
    check_val("flush_wait_next_addr", bus.inst_addr, 32'hbfc00380);

    // flush in OUT during a stall
    wait_valid("flush_out_reach");
    check_val("flush_out_pc", if_pc, 32'hbfc00380);
    check_val("flush_out_inst", if_inst, mem_word(32'hbfc00380));
    flush = 1'b1;
    target = 32'hbfc00400;
    @(negedge clk);
    check_val("flush_out_pc_en", 32'(pc_en), 32'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    check_val("flush_out_valid_drop", 32'(if_valid), 32'd0);
    push_exp(32'hbfc00400);
    step();
    pipe_stall = 1'b0;
    wait_consumes(6, "flush_out_target");
    pipe_stall = 1'b1;

`ifdef IFETCH_ADEL_EN
    // misaligned PC: no bus request, address-error instruction presented
    wait_valid("adel_park");
    flush = 1'b1;
    target = 32'hbfc00002;
    step();
    flush = 1'b0;
    req_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.inst_req) req_seen = 1'b1;
      if (if_valid) break;
    end
    check_val("adel_no_req", 32'(req_seen), 32'd0);
    check_val("adel_valid", 32'(if_valid), 32'd1);
    check_val("adel_flag", 32'(if_adel), 32'd1);
    check_val("adel_inst", if_inst, 32'd0);
    check_val("adel_pc", if_pc, 32'hbfc00002);
`else
    req_seen = 1'b0;
    wait_valid("park_after_target");
    check_val("adel_tied_low", 32'(if_adel), 32'd0);
    check_val("park_no_req", 32'(bus.inst_req | req_seen), 32'd0);
`endif

    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
